// File: rtl/sseg_scan_decoder.sv
// ---------------------------------------------------------------------------
// sseg_scan_decoder
// Monitors the active-low anode/cathode bus of a multiplexed seven-segment
// display and rebuilds the displayed hex value, decimal points and glyph
// validity per digit. Frame_Done pulses once every digit has been seen;
// Bad_Pattern pulses on an illegal glyph or a multi-anode sample.
//
// Build option: define SSEG_DEC_ALT_GLYPH_EN to also accept the alternate
// glyphs 6F (as 9) and 27 (as 7). Without it those glyphs are illegal.
// ---------------------------------------------------------------------------
module sseg_scan_decoder #(
   parameter int NUM_DIGITS    = 8,
   parameter int STABLE_CYCLES = 16
) (
   input  logic                    CLK100MHZ,
   input  logic                    CPU_RESETN,
   input  logic [NUM_DIGITS-1:0]   AN,
   input  logic [7:0]              CA,
   output logic [4*NUM_DIGITS-1:0] Value,
   output logic [NUM_DIGITS-1:0]   DP_Out,
   output logic [NUM_DIGITS-1:0]   Digit_Valid,
   output logic                    Frame_Done,
   output logic                    Bad_Pattern
);

   localparam int BUS_W = NUM_DIGITS + 8;
   localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
   // Last count value seen before moving to SAMPLE; together with the
   // synchronizer and change-detect stages this gives STABLE_CYCLES+3 edges
   // from a pin change to the registered outputs.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 2);

   typedef enum logic [1:0] {
      ST_SETTLE,
      ST_SAMPLE,
      ST_HOLD
   } state_t;

   logic [BUS_W-1:0]      sync1, sync2, prev;
   logic                  changed;
   state_t                state, next_state;
   logic [CNT_W-1:0]      count, next_count;
   logic                  sample_en;

   logic [NUM_DIGITS-1:0] an_low;
   logic [6:0]            seg;
   logic                  an_single, an_multi;
   logic                  glyph_legal, glyph_blank;
   logic [3:0]            glyph_nib;

   logic [NUM_DIGITS-1:0] seen, seen_next;
   logic                  frame_full;

   // Returns {legal, nibble} for a segment pattern (gfedcba, active-high).
   function automatic logic [4:0] decode_glyph(input logic [6:0] s);
      logic [4:0] r;
      r = 5'b0_0000;
      case (s)
         7'h3F: r = {1'b1, 4'h0};
         7'h06: r = {1'b1, 4'h1};
         7'h5B: r = {1'b1, 4'h2};
         7'h4F: r = {1'b1, 4'h3};
         7'h66: r = {1'b1, 4'h4};
         7'h6D: r = {1'b1, 4'h5};
         7'h7D: r = {1'b1, 4'h6};
         7'h07: r = {1'b1, 4'h7};
         7'h7F: r = {1'b1, 4'h8};
         7'h67: r = {1'b1, 4'h9};
         7'h77: r = {1'b1, 4'hA};
         7'h7C: r = {1'b1, 4'hB};
         7'h39: r = {1'b1, 4'hC};
         7'h5E: r = {1'b1, 4'hD};
         7'h79: r = {1'b1, 4'hE};
         7'h71: r = {1'b1, 4'hF};
`ifdef SSEG_DEC_ALT_GLYPH_EN
         7'h6F: r = {1'b1, 4'h9};
         7'h27: r = {1'b1, 4'h7};
`endif
         default: r = 5'b0_0000;
      endcase
      return r;
   endfunction

   // Two-flop synchronizer plus previous-sample register; idle value is
   // all ones (display off).
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge value of its source; blocking here would collapse the chain.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         sync1 <= '1;
         sync2 <= '1;
         prev  <= '1;
      end else begin
         sync1 <= {AN, CA};
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign changed = (sync2 != prev);

   // FSM state and stability counter register.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state <= ST_SETTLE;
         count <= '0;
      end else begin
         state <= next_state;
         count <= next_count;
      end
   end

   // Next-state logic: settle on a stable bus, sample once, hold until change.
   // NOTE: every variable gets a default at the top of an always_comb so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      next_state = state;
      next_count = count;
      case (state)
         ST_SETTLE: begin
            if (changed) begin
               next_count = '0;
            end else if (count == CNT_LAST) begin
               next_state = ST_SAMPLE;
               next_count = '0;
            end else begin
               next_count = count + 1'b1;
            end
         end
         ST_SAMPLE: begin
            // A change landing during the sample cycle must not be lost.
            next_state = changed ? ST_SETTLE : ST_HOLD;
            next_count = '0;
         end
         ST_HOLD: begin
            if (changed) begin
               next_state = ST_SETTLE;
               next_count = '0;
            end
         end
         default: begin
            next_state = ST_SETTLE;
            next_count = '0;
         end
      endcase
   end

   assign sample_en = (state == ST_SAMPLE);

   // Anode classification and glyph decode of the stable sample.
   always_comb begin
      an_low      = ~prev[BUS_W-1:8];
      seg         = ~prev[6:0];
      an_single   = (an_low != '0) &&
                    ((an_low & (an_low - NUM_DIGITS'(1))) == '0);
      an_multi    = (an_low != '0) && !an_single;
      glyph_blank = (seg == 7'h00);
      {glyph_legal, glyph_nib} = decode_glyph(seg);
   end

   // Seen-mask update: a full mask is cleared on the edge that raises
   // Frame_Done, and a sample taken in that cycle starts the new frame.
   always_comb begin
      frame_full = &seen;
      seen_next  = frame_full ? '0 : seen;
      if (sample_en && an_single) begin
         seen_next = seen_next | an_low;
      end
   end

   // Output registers: decoded data written only in SAMPLE; pulses self-clear.
   // NOTE: every register here, including the per-digit value store, is
   // cleared by reset so a partial frame never survives it.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         Value       <= '0;
         DP_Out      <= '0;
         Digit_Valid <= '0;
         Frame_Done  <= 1'b0;
         Bad_Pattern <= 1'b0;
         seen        <= '0;
      end else begin
         Frame_Done  <= frame_full;
         Bad_Pattern <= 1'b0;
         seen        <= seen_next;
         if (sample_en) begin
            if (an_multi) begin
               Bad_Pattern <= 1'b1;
            end else if (an_single) begin
               if (!glyph_legal && !glyph_blank) begin
                  Bad_Pattern <= 1'b1;
               end
               for (int i = 0; i < NUM_DIGITS; i++) begin
                  if (an_low[i]) begin
                     Value[4*i +: 4] <= glyph_legal ? glyph_nib : 4'h0;
                     Digit_Valid[i]  <= glyph_legal;
                     DP_Out[i]       <= ~prev[7];
                  end
               end
            end
         end
      end
   end

endmodule
